// File: rtl/mesh_job_scheduler_if.sv
// Host-side handshake bundle for mesh_job_scheduler: weight stream,
// input vector and result channels, each with valid/ready flow control.
interface mesh_job_scheduler_if #(
   parameter int DW    = 8,
   parameter int ROWS  = 2,
   parameter int COLS  = 2,
   parameter int ACC_W = 16
);
   logic                  w_valid;
   logic                  w_ready;
   logic [DW-1:0]         w_data;
   logic                  x_valid;
   logic                  x_ready;
   logic [COLS*DW-1:0]    x_data;
   logic                  r_valid;
   logic                  r_ready;
   logic [ROWS*ACC_W-1:0] r_data;

   // Host side: produces weights and vectors, consumes results.
   modport master (
      output w_valid, w_data, x_valid, x_data, r_ready,
      input  w_ready, x_ready, r_valid, r_data
   );

   // Scheduler side.
   modport slave (
      input  w_valid, w_data, x_valid, x_data, r_ready,
      output w_ready, x_ready, r_valid, r_data
   );
endinterface

// File: rtl/mesh_job_scheduler.sv
// Sequences a small weight-stationary mesh: streams a full weight set into
// the mesh preload port, then runs one matrix-vector job per input vector,
// waits a fixed compute latency and hands the captured result to the host.
module mesh_job_scheduler #(
   parameter int DW          = 8,
   parameter int ROWS        = 2,
   parameter int COLS        = 2,
   parameter int ROW_W       = 1,
   parameter int COL_W       = 1,
   parameter int ACC_W       = 16,
   parameter int COMPUTE_LAT = 6
) (
   input  logic                      clk,
   input  logic                      rst,
   mesh_job_scheduler_if.slave       host,
   output logic                      mesh_preload_valid,
   output logic [ROW_W+COL_W-1:0]    mesh_preload_addr,
   output logic [DW-1:0]             mesh_preload_data,
   output logic                      mesh_start,
   output logic [COLS*DW-1:0]        mesh_x_vector_flat,
   input  logic [ROWS*ACC_W-1:0]     mesh_result_flat,
   output logic                      wts_loaded,
   output logic                      busy
);

   localparam int IDX_W = ROW_W + COL_W;
   localparam int CNT_W = (COMPUTE_LAT > 1) ? $clog2(COMPUTE_LAT) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROWS*COLS - 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(COMPUTE_LAT - 1);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_LOAD_W  = 3'd1;
   localparam logic [2:0] S_START   = 3'd2;
   localparam logic [2:0] S_COMPUTE = 3'd3;
   localparam logic [2:0] S_OUT     = 3'd4;

   logic [2:0]              state_q,  state_d;
   logic [IDX_W-1:0]        idx_q,    idx_d;
   logic [CNT_W-1:0]        cnt_q,    cnt_d;
   logic                    wts_q,    wts_d;
   logic                    pv_q,     pv_d;
   logic [IDX_W-1:0]        paddr_q,  paddr_d;
   logic [DW-1:0]           pdata_q,  pdata_d;
   logic                    start_q,  start_d;
   logic [COLS*DW-1:0]      xvec_q,   xvec_d;
   logic                    rvalid_q, rvalid_d;
   logic [ROWS*ACC_W-1:0]   rdata_q,  rdata_d;

   logic w_fire;
   logic x_fire;

   // Weight loads win over a vector offered in the same cycle.
   assign host.w_ready = (state_q == S_IDLE) || (state_q == S_LOAD_W);
   assign host.x_ready = (state_q == S_IDLE) && wts_q && !host.w_valid;
   assign w_fire       = host.w_valid && host.w_ready;
   assign x_fire       = host.x_valid && host.x_ready;

   assign host.r_valid       = rvalid_q;
   assign host.r_data        = rdata_q;
   assign mesh_preload_valid = pv_q;
   assign mesh_preload_addr  = paddr_q;
   assign mesh_preload_data  = pdata_q;
   assign mesh_start         = start_q;
   assign mesh_x_vector_flat = xvec_q;
   assign wts_loaded         = wts_q;
   assign busy               = (state_q != S_IDLE);

   // Next-state logic for the job FSM and every registered output.
   always_comb begin
      // NOTE: every variable assigned here gets a default first, so no path
      // leaves one unassigned and no latch is inferred.
      state_d  = state_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      wts_d    = wts_q;
      pv_d     = 1'b0;
      paddr_d  = paddr_q;
      pdata_d  = pdata_q;
      start_d  = 1'b0;
      xvec_d   = xvec_q;
      rvalid_d = rvalid_q;
      rdata_d  = rdata_q;

      case (state_q)
         S_IDLE, S_LOAD_W: begin
            if (w_fire) begin
               pv_d    = 1'b1;
               paddr_d = {ROW_W'(idx_q / COLS), COL_W'(idx_q % COLS)};
               pdata_d = host.w_data;
               if (idx_q == LAST_IDX) begin
                  idx_d   = '0;
                  wts_d   = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  // A partial set is never usable, so drop the flag at once.
                  idx_d   = idx_q + IDX_W'(1);
                  wts_d   = 1'b0;
                  state_d = S_LOAD_W;
               end
            end else if (x_fire) begin
               xvec_d  = host.x_data;
               start_d = 1'b1;
               state_d = S_START;
            end
         end
         S_START: begin
            cnt_d   = '0;
            state_d = S_COMPUTE;
         end
         S_COMPUTE: begin
            if (cnt_q == LAST_CNT) begin
               rdata_d  = mesh_result_flat;
               rvalid_d = 1'b1;
               state_d  = S_OUT;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_OUT: begin
            if (host.r_ready) begin
               rvalid_d = 1'b0;
               state_d  = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State registers; reset aborts any load or job and forgets the weights.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values regardless of statement order.
      if (rst) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         cnt_q    <= '0;
         wts_q    <= 1'b0;
         pv_q     <= 1'b0;
         paddr_q  <= '0;
         pdata_q  <= '0;
         start_q  <= 1'b0;
         xvec_q   <= '0;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         cnt_q    <= cnt_d;
         wts_q    <= wts_d;
         pv_q     <= pv_d;
         paddr_q  <= paddr_d;
         pdata_q  <= pdata_d;
         start_q  <= start_d;
         xvec_q   <= xvec_d;
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
      end
   end

endmodule

// File: tb/tb_mesh_job_scheduler.sv
// Directed bench for mesh_job_scheduler with a behavioural 2x2 mesh that
// only presents a valid product COMPUTE_LAT cycles after mesh_start.
module tb_mesh_job_scheduler;

   localparam int DW    = 8;
   localparam int ROWS  = 2;
   localparam int COLS  = 2;
   localparam int ROW_W = 1;
   localparam int COL_W = 1;
   localparam int ACC_W = 16;
   localparam int LAT   = 6;

   logic                      clk = 1'b0;
   logic                      rst;
   logic                      mesh_preload_valid;
   logic [ROW_W+COL_W-1:0]    mesh_preload_addr;
   logic [DW-1:0]             mesh_preload_data;
   logic                      mesh_start;
   logic [COLS*DW-1:0]        mesh_x_vector_flat;
   logic [ROWS*ACC_W-1:0]     mesh_result_flat;
   logic                      wts_loaded;
   logic                      busy;

   int total = 0;
   int bad   = 0;

   mesh_job_scheduler_if #(.DW(DW), .ROWS(ROWS), .COLS(COLS), .ACC_W(ACC_W)) host_if ();

   mesh_job_scheduler #(
      .DW(DW), .ROWS(ROWS), .COLS(COLS), .ROW_W(ROW_W), .COL_W(COL_W),
      .ACC_W(ACC_W), .COMPUTE_LAT(LAT)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .host               (host_if.slave),
      .mesh_preload_valid (mesh_preload_valid),
      .mesh_preload_addr  (mesh_preload_addr),
      .mesh_preload_data  (mesh_preload_data),
      .mesh_start         (mesh_start),
      .mesh_x_vector_flat (mesh_x_vector_flat),
      .mesh_result_flat   (mesh_result_flat),
      .wts_loaded         (wts_loaded),
      .busy               (busy)
   );

   always #5 clk = ~clk;

   // Mesh model: weight store plus a latency counter gating the result.
   logic signed [DW-1:0]    wmem [ROWS*COLS];
   int                      mcnt;
   logic signed [ACC_W-1:0] m_acc;
   logic signed [DW-1:0]    m_x;

   initial begin
      for (int k = 0; k < ROWS*COLS; k++) wmem[k] = '0;
      mcnt = 0;
   end

   always @(posedge clk) begin
      if (mesh_preload_valid) wmem[mesh_preload_addr] <= mesh_preload_data;
      if (rst)                          mcnt <= 0;
      else if (mesh_start)              mcnt <= 1;
      else if (mcnt != 0 && mcnt < LAT) mcnt <= mcnt + 1;
   end

   always_comb begin
      mesh_result_flat = '0;
      m_acc = '0;
      m_x   = '0;
      for (int i = 0; i < ROWS; i++) begin
         m_acc = '0;
         for (int j = 0; j < COLS; j++) begin
            m_x   = mesh_x_vector_flat[j*DW +: DW];
            m_acc = m_acc + ACC_W'(wmem[i*COLS+j]) * ACC_W'(m_x);
         end
         mesh_result_flat[i*ACC_W +: ACC_W] = (mcnt >= LAT) ? m_acc : ACC_W'(16'hDEAD);
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Streams four weight words back-to-back and checks each preload pulse.
   task automatic load4(input logic [DW-1:0] base, input string tag);
      for (int i = 0; i < 4; i++) begin
         host_if.w_valid = 1'b1;
         host_if.w_data  = base + DW'(i);
         tick();
         check({tag, "_preload"}, {mesh_preload_valid, mesh_preload_addr, mesh_preload_data},
               {1'b1, 2'(i), base + DW'(i)});
         check({tag, "_wts_loaded"}, wts_loaded, (i == 3));
      end
      host_if.w_valid = 1'b0;
      tick();
      check({tag, "_after"}, {mesh_preload_valid, wts_loaded, busy}, 3'b010);
   endtask

   // Offers one vector, checks the start pulse, latency and captured result.
   task automatic run_job(input logic [COLS*DW-1:0] xd, input logic [ROWS*ACC_W-1:0] exp,
                          input string tag);
      int n;
      int starts;
      host_if.x_valid = 1'b1;
      host_if.x_data  = xd;
      #1;
      check({tag, "_x_ready"}, host_if.x_ready, 1'b1);
      tick();
      host_if.x_valid = 1'b0;
      check({tag, "_start"}, {mesh_start, busy, mesh_x_vector_flat}, {2'b11, xd});
      n = 0;
      starts = 0;
      while (!host_if.r_valid && n < 20) begin
         tick();
         n++;
         if (mesh_start) starts++;
      end
      check({tag, "_latency"}, 64'(n), 64'(LAT + 1));
      check({tag, "_one_start"}, 64'(starts), 64'd0);
      check({tag, "_r_data"}, host_if.r_data, exp);
   endtask

   initial begin
      rst             = 1'b1;
      host_if.w_valid = 1'b0;
      host_if.w_data  = '0;
      host_if.x_valid = 1'b0;
      host_if.x_data  = '0;
      host_if.r_ready = 1'b0;

      // Reset state.
      tick();
      tick();
      check("reset_ctrl", {busy, wts_loaded, mesh_preload_valid, mesh_start, host_if.r_valid},
            5'b00000);
      check("reset_data", {mesh_preload_addr, mesh_preload_data, mesh_x_vector_flat, host_if.r_data},
            '0);
      rst = 1'b0;
      #1;
      check("reset_ready", {host_if.w_ready, host_if.x_ready}, 2'b10);

      // Vector offered without weights must be refused.
      host_if.x_valid = 1'b1;
      host_if.x_data  = {8'd6, 8'd5};
      for (int c = 0; c < 3; c++) begin
         tick();
         check("gate_no_start", {host_if.x_ready, mesh_start, busy}, 3'b000);
      end
      host_if.x_valid = 1'b0;

      // Weights [[1,2],[3,4]] streamed row-major.
      load4(8'd1, "load1");

      // Job x=(5,6): rows 1*5+2*6=17, 3*5+4*6=39.
      run_job({8'd6, 8'd5}, {16'd39, 16'd17}, "job1");

      // Result held under backpressure; no new work accepted meanwhile.
      host_if.x_valid = 1'b1;
      for (int c = 0; c < 10; c++) begin
         tick();
         check("bp_hold", {host_if.r_valid, host_if.x_ready, host_if.w_ready, host_if.r_data},
               {3'b100, 16'd39, 16'd17});
      end
      host_if.x_valid = 1'b0;
      host_if.r_ready = 1'b1;
      tick();
      check("bp_release", {host_if.r_valid, busy, wts_loaded}, 3'b001);

      // r_ready held high through a whole job; weights reused.
      // x=(-1,2): rows 1*-1+2*2=3, 3*-1+4*2=5.
      run_job({8'd2, 8'hFF}, {16'd5, 16'd3}, "job2");
      tick();
      check("job2_taken", {host_if.r_valid, busy}, 2'b00);
      host_if.r_ready = 1'b0;

      // Weight and vector together: the weight wins.
      host_if.w_valid = 1'b1;
      host_if.w_data  = 8'd10;
      host_if.x_valid = 1'b1;
      host_if.x_data  = {8'd1, 8'd1};
      #1;
      check("prio_ready", {host_if.x_ready, host_if.w_ready}, 2'b01);
      tick();
      host_if.x_valid = 1'b0;
      check("prio_w_taken", {mesh_preload_valid, mesh_preload_addr, mesh_preload_data},
            {1'b1, 2'd0, 8'd10});
      check("prio_state", {wts_loaded, mesh_start, busy}, 3'b001);
      host_if.w_data = 8'd20;
      tick();
      check("abort_word1", {mesh_preload_valid, mesh_preload_addr, mesh_preload_data},
            {1'b1, 2'd1, 8'd20});

      // Reset after two of four words, with w_valid still offered.
      rst = 1'b1;
      host_if.w_data = 8'd30;
      for (int c = 0; c < 2; c++) begin
         tick();
         check("abort_in_reset", {mesh_preload_valid, wts_loaded, busy}, 3'b000);
      end
      rst = 1'b0;
      host_if.w_valid = 1'b0;
      tick();
      check("abort_after", {mesh_preload_valid, wts_loaded, busy, host_if.x_ready}, 4'b0000);

      // Full reload [[5,6],[7,8]] restarts at address 0.
      load4(8'd5, "load2");

      // Job x=(1,1): rows 5+6=11, 7+8=15.
      host_if.r_ready = 1'b1;
      run_job({8'd1, 8'd1}, {16'd15, 16'd11}, "job3");
      tick();
      host_if.r_ready = 1'b0;
      check("job3_taken", {host_if.r_valid, busy, wts_loaded}, 3'b001);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mesh_job_scheduler.md
MESH_JOB_SCHEDULER -- requirements
Module: mesh_job_scheduler

Interface
REQ-001 SHALL have parameter DW, default 8, signed data width of weights and vector elements.
REQ-002 SHALL have parameters ROWS, default 2, and COLS, default 2, the mesh dimensions.
REQ-003 SHALL have parameters ROW_W, default 1, and COL_W, default 1, the row and column index widths.
REQ-004 SHALL have parameter ACC_W, default 16, the per-row result width.
REQ-005 SHALL have parameter COMPUTE_LAT, default 6, the cycles from mesh_start pulse to valid mesh_result_flat.
REQ-006 SHALL have ports: clk in 1, sole clock; rst in 1, reset (one clock; reset is synchronous and active-high).
REQ-007 SHALL have ports: w_valid in 1; w_ready out 1; w_data in DW, weight stream, row-major, ROWS*COLS words per load.
REQ-008 SHALL have ports: x_valid in 1; x_ready out 1; x_data in COLS*DW, input vector.
REQ-009 SHALL have ports: r_valid out 1; r_ready in 1; r_data out ROWS*ACC_W, captured result.
REQ-010 SHALL have ports: mesh_preload_valid out 1; mesh_preload_addr out ROW_W+COL_W; mesh_preload_data out DW.
REQ-011 SHALL have ports: mesh_start out 1, compute pulse; mesh_x_vector_flat out COLS*DW; mesh_result_flat in ROWS*ACC_W.
REQ-012 SHALL have ports: wts_loaded out 1, full weight set resident; busy out 1, state not IDLE.

Function
REQ-013 SHALL implement states IDLE, LOAD_W, START, COMPUTE, OUT.
REQ-014 SHALL drive w_ready=1 only in IDLE and LOAD_W; a transfer occurs on w_valid&&w_ready.
REQ-015 SHALL, in IDLE, move to LOAD_W on a w transfer, clear wts_loaded and set the word index to 1.
REQ-016 SHALL, for each w transfer at cycle t, assert mesh_preload_valid at t+1 for exactly 1 cycle, with mesh_preload_data=w_data and mesh_preload_addr={idx/COLS, idx%COLS}, where idx is the pre-transfer word index (0..ROWS*COLS-1).
REQ-017 SHALL, in LOAD_W, on the transfer of word ROWS*COLS-1, set wts_loaded=1 the next cycle and return to IDLE; a w_valid gap stalls LOAD_W indefinitely.
REQ-018 SHALL drive x_ready=1 only in IDLE with wts_loaded=1 and w_valid=0, so a weight update has priority over a simultaneous vector.
REQ-019 SHALL, on an x transfer, register x_data into mesh_x_vector_flat and enter START.
REQ-020 SHALL hold mesh_x_vector_flat until the next x transfer.
REQ-021 SHALL pulse mesh_start for 1 cycle in START, then enter COMPUTE with counter=0.
REQ-022 SHALL increment the counter each cycle in COMPUTE and, when counter==COMPUTE_LAT-1, register mesh_result_flat into r_data and enter OUT.
REQ-023 SHALL drive r_valid=1 throughout OUT, with r_data stable; on r_ready it SHALL return to IDLE.
REQ-024 SHALL ignore r_ready outside OUT.
REQ-025 SHALL keep wts_loaded=1 across jobs, so weights are reused until the next weight load.
REQ-026 SHALL keep w_valid, x_valid and r_ready dependent outputs combinational; all mesh_* outputs SHALL be registered.

Reset
REQ-027 SHALL, while rst=1 at a clk edge, set state=IDLE, the index and counter to 0, and wts_loaded=0.
REQ-028 SHALL, in the same reset, set mesh_preload_valid, mesh_start and r_valid to 0, and mesh_preload_addr, mesh_preload_data, mesh_x_vector_flat and r_data to 0.
REQ-029 SHALL allow reset mid-LOAD_W, mid-COMPUTE or in OUT to abort the operation; it SHALL issue no further mesh_preload_valid or mesh_start and SHALL require a full weight reload.

Verification
REQ-030 SHALL verify weight load: after reset, stream 4 words 1,2,3,4 back-to-back -> preload addr 0,1,2,3 with data 1,2,3,4 on consecutive cycles, and wts_loaded=1 after the 4th.
REQ-031 SHALL verify gating: x_valid=1 with wts_loaded=0 -> x_ready stays 0, and no mesh_start occurs.
REQ-032 SHALL verify a job: weights [[1,2],[3,4]], x=(5,6), mesh model -> mesh_start 1 cycle after the x transfer, r_valid exactly COMPUTE_LAT+1 cycles after mesh_start, and r_data rows = 17, 39.
REQ-033 SHALL verify backpressure: r_ready held 0 for 10 cycles -> r_valid and r_data stable, with x_ready=0 and w_ready=0 throughout.
REQ-034 SHALL verify priority: in IDLE with w_valid=1 and x_valid=1 together -> w accepted, x_ready=0, and wts_loaded drops to 0.
REQ-035 SHALL verify reset abort: rst asserted after 2 of 4 weight words -> wts_loaded=0, index restarts at addr 0 on the next load, and no preload pulse occurs during reset.
